// File: rtl/lut_cfg_pkg.sv
// Shared types for the LUT configuration loader: FSM states and the
// 3-input LUT truth-table mask type.
package lut_cfg_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, FAIL} lut_cfg_state_e;
  localparam int LUT_MASK_W = 8;
  typedef logic [LUT_MASK_W-1:0] lut_mask_t;
endpackage

// File: rtl/lut_mask_bank.sv
// Shadow and active mask registers, one lane per LUT. The active copy only
// changes on commit/clear, so a reload never exposes a partial configuration.
module lut_mask_bank
  import lut_cfg_pkg::*;
#(
  parameter int NUM_LUTS = 4,
  parameter int IDX_W    = $clog2(NUM_LUTS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [LUT_MASK_W-1:0]          wr_data,
  input  logic                           commit,
  input  logic                           clear,
  output logic [NUM_LUTS*LUT_MASK_W-1:0] active
);

  for (genvar n = 0; n < NUM_LUTS; n++) begin : g_lane
    lut_mask_t shadow;
    lut_mask_t act;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow <= '0;
        act    <= '0;
      end else if (clear) begin
        shadow <= '0;
        act    <= '0;
      end else begin
        if (wr_en && wr_idx == IDX_W'(n)) shadow <= wr_data;
        if (commit) act <= shadow;
      end
    end

    assign active[n*LUT_MASK_W +: LUT_MASK_W] = act;
  end

endmodule

// File: rtl/lut_cfg_loader.sv
// Streams NUM_LUTS mask beats plus an XOR checksum beat into shadow registers,
// then commits them atomically to the LUT mask outputs if the checksum matches.
module lut_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter  int NUM_LUTS = 4,
  localparam int IDX_W    = $clog2(NUM_LUTS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  logic                           cfg_valid_i,
  input  logic [LUT_MASK_W-1:0]          cfg_data_i,
  output logic                           cfg_ready_o,
  output logic [NUM_LUTS*LUT_MASK_W-1:0] cfg_mask_o,
  output logic                           lut_en_o,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LUTS - 1);

  lut_cfg_state_e   state, state_n;
  logic [IDX_W-1:0] count;
  lut_mask_t        csum;
  logic             do_start, wr_en, commit, clear;

  assign cfg_ready_o = (state == LOAD) || (state == CHECK);

  // Abort takes priority over a beat presented in the same cycle.
  always_comb begin
    state_n  = state;
    do_start = 1'b0;
    wr_en    = 1'b0;
    commit   = 1'b0;
    clear    = 1'b0;
    unique case (state)
      IDLE, DONE, FAIL: begin
        if (start_i) begin
          state_n  = LOAD;
          do_start = 1'b1;
        end
      end
      LOAD: begin
        if (abort_i) state_n = IDLE;
        else if (cfg_valid_i) begin
          wr_en = 1'b1;
          if (count == LAST_IDX) state_n = CHECK;
        end
      end
      CHECK: begin
        if (abort_i) state_n = IDLE;
        else if (cfg_valid_i) begin
          if (cfg_data_i == csum) begin
            commit  = 1'b1;
            state_n = DONE;
          end else begin
            clear   = 1'b1;
            state_n = FAIL;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      csum     <= '0;
      busy_o   <= 1'b0;
      err_o    <= 1'b0;
      lut_en_o <= 1'b0;
    end else begin
      state  <= state_n;
      busy_o <= (state_n == LOAD) || (state_n == CHECK);
      if (do_start) begin
        count <= '0;
        csum  <= '0;
        err_o <= 1'b0;
      end
      if (wr_en) begin
        count <= count + 1'b1;
        csum  <= csum ^ cfg_data_i;
      end
      if (commit) lut_en_o <= 1'b1;
      if (clear) begin
        lut_en_o <= 1'b0;
        err_o    <= 1'b1;
      end
    end
  end

  lut_mask_bank #(.NUM_LUTS(NUM_LUTS), .IDX_W(IDX_W)) u_bank (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_idx (count),
    .wr_data(cfg_data_i),
    .commit (commit),
    .clear  (clear),
    .active (cfg_mask_o)
  );

endmodule
